// File: rtl/iir_coef_ctrl.sv
// -----------------------------------------------------------------------------
// iir_coef_ctrl
// Coefficient manager for a biquad IIR filter. Software writes new
// coefficients into a shadow bank at any time; an update request drains the
// filter for DRAIN_CYC idle cycles and then copies the whole shadow bank into
// the active bank in a single edge, so the filter never sees a mixed set.
// The sample path from the upstream source is registered and is stalled
// while an update is in progress.
//
// Ports
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_cfg_we/addr/data       coefficient write (addr 0=b0 1=b1 2=b2 3=a1 4=a2)
//   o_cfg_ack / o_cfg_err    one-cycle response: valid / invalid address
//   i_upd_req                commit shadow coefficients to the filter
//   o_upd_busy / o_upd_done  update in progress / new coefficients active
//   i_src_din, i_src_vin     upstream sample and valid
//   o_src_rdy                sample accepted this cycle
//   o_din, o_vin             registered sample and valid to the filter
//   o_b0..o_a2               active coefficients
// -----------------------------------------------------------------------------
module iir_coef_ctrl #(
  parameter int DW        = 9,
  parameter int DRAIN_CYC = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_cfg_we,
  input  logic [2:0]    i_cfg_addr,
  input  logic [DW-1:0] i_cfg_data,
  output logic          o_cfg_ack,
  output logic          o_cfg_err,
  input  logic          i_upd_req,
  output logic          o_upd_busy,
  output logic          o_upd_done,
  input  logic [DW-1:0] i_src_din,
  input  logic          i_src_vin,
  output logic          o_src_rdy,
  output logic [DW-1:0] o_din,
  output logic          o_vin,
  output logic [DW-1:0] o_b0,
  output logic [DW-1:0] o_b1,
  output logic [DW-1:0] o_b2,
  output logic [DW-1:0] o_a1,
  output logic [DW-1:0] o_a2
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYC - 1);

  logic [1:0]    r_state;
  logic [3:0]    r_drainCnt;
  logic          r_pending;
  logic [DW-1:0] r_shadow [5];
  logic [DW-1:0] r_active [5];
  logic [DW-1:0] r_din;
  logic          r_vin;
  logic          r_ack;
  logic          r_err;
  logic          r_done;

  logic          w_wrValid;
  logic          w_wrInvalid;
  logic          w_accept;

  assign w_wrValid   = i_cfg_we && (i_cfg_addr <= 3'd4);
  assign w_wrInvalid = i_cfg_we && (i_cfg_addr > 3'd4);
  assign o_src_rdy   = (r_state == S_RUN);
  assign o_upd_busy  = (r_state == S_DRAIN) || (r_state == S_COMMIT);
  assign w_accept    = i_src_vin && o_src_rdy;

  // Shadow bank: writable in every state. In the commit cycle the active bank
  // samples the old shadow value because both update on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 5; k++) r_shadow[k] <= '0;
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (w_wrValid && (i_cfg_addr == 3'(k))) r_shadow[k] <= i_cfg_data;
      end
    end
  end

  // Write response pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ack <= w_wrValid;
      r_err <= w_wrInvalid;
    end
  end

  // A write landing in the commit cycle is not part of the committed set, so
  // it must keep the pending flag alive for a later update.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending <= 1'b0;
    end else if (r_state == S_COMMIT) begin
      r_pending <= w_wrValid;
    end else if (w_wrValid) begin
      r_pending <= 1'b1;
    end
  end

  // Update FSM. Requests while busy are dropped, not queued.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_RUN;
      r_drainCnt <= '0;
      r_done     <= 1'b0;
      for (int k = 0; k < 5; k++) r_active[k] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (i_upd_req && r_pending) begin
            r_state    <= S_DRAIN;
            r_drainCnt <= '0;
          end
        end
        S_DRAIN: begin
          if (r_drainCnt == DRAIN_LAST) begin
            r_state <= S_COMMIT;
          end else begin
            r_drainCnt <= r_drainCnt + 4'd1;
          end
        end
        S_COMMIT: begin
          for (int k = 0; k < 5; k++) r_active[k] <= r_shadow[k];
          r_state <= S_RUN;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= S_RUN;
        end
      endcase
    end
  end

  // Sample path: one-cycle registered forward, din holds between accepts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vin <= 1'b0;
      r_din <= '0;
    end else begin
      r_vin <= w_accept;
      if (w_accept) r_din <= i_src_din;
    end
  end

  assign o_cfg_ack  = r_ack;
  assign o_cfg_err  = r_err;
  assign o_upd_done = r_done;
  assign o_vin      = r_vin;
  assign o_din      = r_din;
  assign o_b0       = r_active[0];
  assign o_b1       = r_active[1];
  assign o_b2       = r_active[2];
  assign o_a1       = r_active[3];
  assign o_a2       = r_active[4];

endmodule

// File: tb/tb_iir_coef_ctrl.sv
// -----------------------------------------------------------------------------
// tb_iir_coef_ctrl
// Directed bench for iir_coef_ctrl. Forwarded samples are checked through a
// queue: each sample expected to be accepted is pushed when driven and popped
// when o_vin shows it.
// -----------------------------------------------------------------------------
module tb_iir_coef_ctrl;

  localparam int DW = 9;

  logic          clk;
  logic          rstN;
  logic          cfgWe;
  logic [2:0]    cfgAddr;
  logic [DW-1:0] cfgData;
  logic          cfgAck;
  logic          cfgErr;
  logic          updReq;
  logic          updBusy;
  logic          updDone;
  logic [DW-1:0] srcDin;
  logic          srcVin;
  logic          srcRdy;
  logic [DW-1:0] din;
  logic          vin;
  logic [DW-1:0] b0, b1, b2, a1, a2;

  int            nAssert = 0;
  int            nFail   = 0;
  int            nSamples = 0;
  logic [DW-1:0] sampleQ [$];

  iir_coef_ctrl #(.DW(DW), .DRAIN_CYC(4)) dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_cfg_we   (cfgWe),
    .i_cfg_addr (cfgAddr),
    .i_cfg_data (cfgData),
    .o_cfg_ack  (cfgAck),
    .o_cfg_err  (cfgErr),
    .i_upd_req  (updReq),
    .o_upd_busy (updBusy),
    .o_upd_done (updDone),
    .i_src_din  (srcDin),
    .i_src_vin  (srcVin),
    .o_src_rdy  (srcRdy),
    .o_din      (din),
    .o_vin      (vin),
    .o_b0       (b0),
    .o_b1       (b1),
    .o_b2       (b2),
    .o_a1       (a1),
    .o_a2       (a2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One coefficient write; the response is visible right after the edge.
  task automatic applyStimulus(input logic [2:0] addr, input logic [DW-1:0] data);
    cfgWe   = 1'b1;
    cfgAddr = addr;
    cfgData = data;
    tick();
    cfgWe = 1'b0;
  endtask

  // Pulse upd_req and follow the update to completion.
  task automatic runUpdate(input string tag);
    int busyCyc;
    int guard;
    updReq = 1'b1;
    tick();
    updReq = 1'b0;
    busyCyc = (updBusy === 1'b1) ? 1 : 0;
    guard = 0;
    while (updBusy === 1'b1 && guard < 30) begin
      tick();
      if (updBusy === 1'b1) busyCyc++;
      guard++;
    end
    checkOutput({tag, "_busyCycles"}, 32'(busyCyc), 32'd5);
    checkOutput({tag, "_done"}, 32'(updDone), 32'd1);
  endtask

  // Scoreboard for the sample path.
  always @(negedge clk) begin
    if (rstN === 1'b1 && vin === 1'b1) begin
      nSamples++;
      if (sampleQ.size() == 0) begin
        checkOutput("sampleUnexpected", 32'(din), 32'hFFFF_FFFF);
      end else begin
        checkOutput("sampleData", 32'(din), 32'(sampleQ.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneCnt;
    int busyCnt;
    rstN    = 1'b0;
    cfgWe   = 1'b0;
    cfgAddr = '0;
    cfgData = '0;
    updReq  = 1'b0;
    srcDin  = '0;
    srcVin  = 1'b0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_b0", 32'(b0), 32'd0);
    checkOutput("rst_a2", 32'(a2), 32'd0);
    checkOutput("rst_vin", 32'(vin), 32'd0);
    checkOutput("rst_ack", 32'(cfgAck), 32'd0);
    checkOutput("rst_err", 32'(cfgErr), 32'd0);
    checkOutput("rst_done", 32'(updDone), 32'd0);
    checkOutput("rst_busy", 32'(updBusy), 32'd0);
    checkOutput("rst_rdy", 32'(srcRdy), 32'd1);
    rstN = 1'b1;
    tick();

    // Basic write and commit
    $display("[TB] coefficient write and commit");
    applyStimulus(3'd0, 9'h0A5);
    checkOutput("wr_b0_ack", 32'(cfgAck), 32'd1);
    checkOutput("wr_b0_err", 32'(cfgErr), 32'd0);
    for (int i = 1; i < 5; i++) begin
      applyStimulus(3'(i), 9'(i));
      checkOutput("wr_ack", 32'(cfgAck), 32'd1);
    end
    checkOutput("preUpd_b0", 32'(b0), 32'd0);
    runUpdate("upd1");
    checkOutput("upd1_b0", 32'(b0), 32'h0A5);
    checkOutput("upd1_b1", 32'(b1), 32'd1);
    checkOutput("upd1_b2", 32'(b2), 32'd2);
    checkOutput("upd1_a1", 32'(a1), 32'd3);
    checkOutput("upd1_a2", 32'(a2), 32'd4);
    tick();
    checkOutput("upd1_donePulse", 32'(updDone), 32'd0);

    // Invalid address
    $display("[TB] invalid address");
    applyStimulus(3'd6, 9'h155);
    checkOutput("inv_err", 32'(cfgErr), 32'd1);
    checkOutput("inv_ack", 32'(cfgAck), 32'd0);
    tick();
    checkOutput("inv_errPulse", 32'(cfgErr), 32'd0);
    updReq = 1'b1;
    tick();
    updReq = 1'b0;
    checkOutput("inv_noBusy", 32'(updBusy), 32'd0);
    tick();
    checkOutput("inv_noDone", 32'(updDone), 32'd0);
    checkOutput("inv_b0Kept", 32'(b0), 32'h0A5);

    // Write during COMMIT
    $display("[TB] write in commit cycle");
    applyStimulus(3'd3, 9'h003);
    updReq = 1'b1;
    tick();
    updReq = 1'b0;
    checkOutput("cw_drain1", 32'(updBusy), 32'd1);
    tick();
    tick();
    tick();
    tick();
    checkOutput("cw_commitBusy", 32'(updBusy), 32'd1);
    applyStimulus(3'd3, 9'h1FF);
    checkOutput("cw_done", 32'(updDone), 32'd1);
    checkOutput("cw_a1Old", 32'(a1), 32'h003);
    checkOutput("cw_ack", 32'(cfgAck), 32'd1);
    checkOutput("cw_rdy", 32'(srcRdy), 32'd1);
    runUpdate("upd2");
    checkOutput("upd2_a1", 32'(a1), 32'h1FF);

    // Sample stream across an update
    $display("[TB] sample stream");
    applyStimulus(3'd2, 9'h022);
    srcVin = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      srcDin = 9'(k);
      sampleQ.push_back(9'(k));
      if (k == 7) updReq = 1'b1;
      tick();
    end
    updReq = 1'b0;
    srcDin = 9'd8;
    checkOutput("st_busyStart", 32'(updBusy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("st_rdyLow", 32'(srcRdy), 32'd0);
    end
    tick();
    checkOutput("st_rdyBack", 32'(srcRdy), 32'd1);
    checkOutput("st_done", 32'(updDone), 32'd1);
    checkOutput("st_b2", 32'(b2), 32'h022);
    sampleQ.push_back(9'd8);
    tick();
    srcDin = 9'd9;
    sampleQ.push_back(9'd9);
    tick();
    srcVin = 1'b0;
    tick();
    tick();
    checkOutput("st_queueEmpty", 32'(sampleQ.size()), 32'd0);
    checkOutput("st_sampleCount", 32'(nSamples), 32'd9);

    // Reset during DRAIN
    $display("[TB] reset during drain");
    applyStimulus(3'd0, 9'h033);
    updReq = 1'b1;
    tick();
    updReq = 1'b0;
    tick();
    checkOutput("rd_inDrain", 32'(updBusy), 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("rd_b0", 32'(b0), 32'd0);
    checkOutput("rd_a1", 32'(a1), 32'd0);
    checkOutput("rd_din", 32'(din), 32'd0);
    checkOutput("rd_busy", 32'(updBusy), 32'd0);
    checkOutput("rd_rdy", 32'(srcRdy), 32'd1);
    tick();
    rstN = 1'b1;
    doneCnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (updDone === 1'b1) doneCnt++;
    end
    checkOutput("rd_noDone", 32'(doneCnt), 32'd0);
    checkOutput("rd_b0After", 32'(b0), 32'd0);

    // upd_req held high
    $display("[TB] held update request");
    applyStimulus(3'd1, 9'h011);
    doneCnt = 0;
    busyCnt = 0;
    updReq = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (k == 10) updReq = 1'b0;
      tick();
      if (updDone === 1'b1) doneCnt++;
      if (updBusy === 1'b1) busyCnt++;
    end
    updReq = 1'b0;
    checkOutput("hold_doneCount", 32'(doneCnt), 32'd1);
    checkOutput("hold_busyCount", 32'(busyCnt), 32'd5);
    checkOutput("hold_b1", 32'(b1), 32'h011);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/iir_coef_ctrl.md
IIR_COEF_CTRL -- requirements
Module: iir_coef_ctrl

Interface
REQ-001 Parameter DW, default 9, sets the sample and coefficient width in bits.
REQ-002 Parameter DRAIN_CYC, default 4, sets the number of idle cycles the filter gets before a coefficient swap; legal range 1..15.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 cfg_we  in  1  coefficient write strobe, one write per cycle.
REQ-006 cfg_addr  in  3  coefficient select: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5..7 are invalid.
REQ-007 cfg_data  in  DW  coefficient write value.
REQ-008 cfg_ack  out  1  one-cycle pulse confirming a valid write.
REQ-009 cfg_err  out  1  one-cycle pulse flagging a write to an invalid address.
REQ-010 upd_req  in  1  request to commit the shadow coefficients to the filter.
REQ-011 upd_busy  out  1  high while an update is in progress.
REQ-012 upd_done  out  1  one-cycle pulse once the new coefficients are active.
REQ-013 src_din  in  DW  sample from the upstream source.
REQ-014 src_vin  in  1  sample valid from the upstream source.
REQ-015 src_rdy  out  1  controller accepts a sample this cycle.
REQ-016 din  out  DW  sample to the filter.
REQ-017 vin  out  1  sample valid to the filter.
REQ-018 b0, b1, b2, a1, a2  out  DW each  active coefficients to the filter.

Function
REQ-019 The block SHALL hold two register banks: a 5xDW shadow bank and a 5xDW active bank; only the active bank drives b0..a2.
REQ-020 A write with cfg_we=1 and cfg_addr 0..4 SHALL load the shadow entry at that edge, in any FSM state; cfg_ack SHALL pulse the following cycle.
REQ-021 A write with cfg_addr 5..7 SHALL leave all banks unchanged; cfg_err SHALL pulse the following cycle and cfg_ack SHALL stay low.
REQ-022 A pending flag SHALL set on every valid write and clear on commit, except when a valid write occurs in the COMMIT cycle; in that case the flag stays set.
REQ-023 The FSM SHALL have three states: RUN, DRAIN and COMMIT.
REQ-024 src_rdy SHALL equal 1 in RUN and 0 otherwise (combinational); upd_busy SHALL equal 1 in DRAIN or COMMIT (combinational).
REQ-025 A sample is accepted when src_vin=1 and src_rdy=1.
REQ-026 vin and din SHALL be registered with 1-cycle latency: on each edge, vin gets (src_vin AND src_rdy); din loads src_din on accept and holds otherwise.
REQ-027 RUN->DRAIN SHALL occur when upd_req=1 and pending=1; a sample accepted in that same cycle SHALL still be forwarded.
REQ-028 In RUN, upd_req with pending=0 SHALL be ignored: no state change and no upd_done.
REQ-029 upd_req in DRAIN or COMMIT SHALL be ignored and SHALL NOT be queued.
REQ-030 DRAIN SHALL last exactly DRAIN_CYC cycles, counted by an internal counter, then transition to COMMIT.
REQ-031 COMMIT SHALL last one cycle; at its closing edge all five active entries SHALL load from shadow simultaneously, the FSM SHALL return to RUN, and upd_done SHALL pulse in the first RUN cycle.
REQ-032 Coefficient outputs SHALL never change outside the COMMIT closing edge; no partially updated coefficient set may ever appear.
REQ-033 A write in the COMMIT cycle SHALL update shadow at the same edge; active takes the pre-write shadow value.

Reset
REQ-034 While rst_n=0: shadow, active, din and the drain counter at 0; pending=0; FSM in RUN; vin, cfg_ack, cfg_err and upd_done at 0.
REQ-035 Reset asserted in DRAIN or COMMIT SHALL abort the update immediately; no upd_done SHALL follow.
REQ-036 Outputs SHALL be valid from the first edge after rst_n deasserts.

Verification
REQ-037 Write b0=0x0A5 then b1..a2=1..4, then upd_req -> cfg_ack once per write; upd_busy high 5 cycles (DRAIN_CYC=4); b0..a2 = 0x0A5,1,2,3,4 with upd_done in the same cycle.
REQ-038 Continuous src_vin=1, samples 1,2,3,..., upd_req with sample 7 -> vin shows samples 1..7 with 1-cycle latency; vin=0 for 5 cycles; sample 8 forwarded in the first RUN cycle after COMMIT; no sample lost or duplicated.
REQ-039 Write cfg_addr=6 -> cfg_err pulse, no cfg_ack, pending stays 0; a following upd_req -> no busy, no upd_done.
REQ-040 Write a1=0x1FF in the COMMIT cycle of an update carrying a1=0x003 -> active a1=0x003 after upd_done; a second upd_req -> active a1=0x1FF.
REQ-041 rst_n pulled low in the 2nd DRAIN cycle -> all outputs 0, FSM in RUN, src_rdy=1 after release, no upd_done.
REQ-042 upd_req held high for 10 cycles with one pending write -> exactly one update and one upd_done.
